// File: rtl/tank_pkg.sv
// Shared types and constants for the tank pump controller: level encoding,
// indicator flag codes and FSM states.
package tank_pkg;

  typedef enum logic [2:0] {
    LVL_EMPTY     = 3'd0,
    LVL_LOW       = 3'd1,
    LVL_HALF      = 3'd2,
    LVL_NEAR_FULL = 3'd3,
    LVL_FULL      = 3'd4
  } level_t;

  // Flag patterns are ordered {full, half, empty}
  localparam logic [2:0] CODE_EMPTY     = 3'b000;
  localparam logic [2:0] CODE_LOW       = 3'b011;
  localparam logic [2:0] CODE_HALF      = 3'b010;
  localparam logic [2:0] CODE_NEAR_FULL = 3'b110;
  localparam logic [2:0] CODE_FULL      = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_HOLD,
    ST_FAULT
  } state_t;

  function automatic logic code_valid(input logic [2:0] code);
    return (code == CODE_EMPTY) || (code == CODE_LOW) || (code == CODE_HALF) ||
           (code == CODE_NEAR_FULL) || (code == CODE_FULL);
  endfunction

  function automatic level_t decode_level(input logic [2:0] code);
    level_t lvl;
    lvl = LVL_EMPTY;
    case (code)
      CODE_LOW:       lvl = LVL_LOW;
      CODE_HALF:      lvl = LVL_HALF;
      CODE_NEAR_FULL: lvl = LVL_NEAR_FULL;
      CODE_FULL:      lvl = LVL_FULL;
      default:        lvl = LVL_EMPTY;
    endcase
    return lvl;
  endfunction

endpackage

// File: rtl/tank_pump_controller_level_debouncer.sv
// Registers the level flags, requires a stable code for DEBOUNCE_CYCLES edges
// before accepting it, and flags sustained invalid codes as a fault request.
module level_debouncer
  import tank_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] flags,
  output logic [2:0] level_q,
  output logic       level_valid,
  output logic       sensor_err,
  output logic       invalid_req
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [2:0]    in_q;
  logic [CW-1:0] stable_cnt;

  // A new sample counts as edge 1; in_q is accepted once it has been held
  // for DEBOUNCE_CYCLES edges, even if the input moves on at the accept edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_q        <= CODE_EMPTY;
      stable_cnt  <= '0;
      level_q     <= LVL_EMPTY;
      level_valid <= 1'b0;
      sensor_err  <= 1'b0;
      invalid_req <= 1'b0;
    end else begin
      in_q       <= flags;
      sensor_err <= !code_valid(in_q);
      if (flags != in_q)
        stable_cnt <= CNT_ONE;
      else if (stable_cnt != CNT_MAX)
        stable_cnt <= stable_cnt + CNT_ONE;
      invalid_req <= 1'b0;
      if (stable_cnt == CNT_MAX) begin
        if (code_valid(in_q)) begin
          level_q     <= decode_level(in_q);
          level_valid <= 1'b1;
        end else begin
          invalid_req <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/tank_pump_controller.sv
// Pump fill controller: debounced level input, hysteresis fill FSM with
// post-stop lockout, dry-run timeout and invalid-sensor fault.
module tank_pump_controller
  import tank_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int MIN_OFF_CYCLES  = 8,
  parameter int DRY_TIMEOUT     = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       full,
  input  logic       half,
  input  logic       empty,
  input  logic       fault_clr,
  output logic       pump_on,
  output logic [2:0] level_q,
  output logic       level_valid,
  output logic       sensor_err,
  output logic       fault
);

  localparam int DW = $clog2(DRY_TIMEOUT + 1);
  localparam int OW = $clog2(MIN_OFF_CYCLES + 1);
  localparam logic [DW-1:0] DRY_LAST = DW'(DRY_TIMEOUT - 1);
  localparam logic [OW-1:0] OFF_LAST = OW'(MIN_OFF_CYCLES - 1);
  localparam logic [DW-1:0] DRY_ONE  = DW'(1);
  localparam logic [OW-1:0] OFF_ONE  = OW'(1);

  state_t        state;
  logic [DW-1:0] dry_cnt;
  logic [OW-1:0] off_cnt;
  logic          invalid_req;

  level_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk        (clk),
    .rst        (rst),
    .flags      ({full, half, empty}),
    .level_q    (level_q),
    .level_valid(level_valid),
    .sensor_err (sensor_err),
    .invalid_req(invalid_req)
  );

  // pump_on and fault are updated together with state so they are flop-driven.
  // Transition priority: invalid fault request, then !en, then FULL.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      pump_on <= 1'b0;
      fault   <= 1'b0;
      dry_cnt <= '0;
      off_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (invalid_req) begin
            state <= ST_FAULT;
            fault <= 1'b1;
          end else if (en && level_valid && (level_q <= LVL_LOW)) begin
            state   <= ST_FILL;
            pump_on <= 1'b1;
            dry_cnt <= '0;
          end
        end
        ST_FILL: begin
          if (invalid_req) begin
            state   <= ST_FAULT;
            pump_on <= 1'b0;
            fault   <= 1'b1;
          end else if (!en || (level_q == LVL_FULL)) begin
            state   <= ST_HOLD;
            pump_on <= 1'b0;
            off_cnt <= '0;
          end else if (level_q == LVL_EMPTY) begin
            if (dry_cnt >= DRY_LAST) begin
              state   <= ST_FAULT;
              pump_on <= 1'b0;
              fault   <= 1'b1;
            end else begin
              dry_cnt <= dry_cnt + DRY_ONE;
            end
          end else begin
            dry_cnt <= '0;
          end
        end
        ST_HOLD: begin
          if (invalid_req) begin
            state <= ST_FAULT;
            fault <= 1'b1;
          end else if (off_cnt >= OFF_LAST) begin
            state <= ST_IDLE;
          end else begin
            off_cnt <= off_cnt + OFF_ONE;
          end
        end
        ST_FAULT: begin
          if (!invalid_req && fault_clr) begin
            state   <= ST_HOLD;
            fault   <= 1'b0;
            off_cnt <= '0;
          end
        end
        default: begin
          state   <= ST_IDLE;
          pump_on <= 1'b0;
          fault   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tank_pump_controller.sv
// Directed bench for tank_pump_controller: a vector table walks the fill cycle,
// followed by hand-written async-reset and dry-run sequences.
module tb_tank_pump_controller;

  logic       clk;
  logic       rst;
  logic       en;
  logic       full;
  logic       half;
  logic       empty;
  logic       fault_clr;
  logic       pump_on;
  logic [2:0] level_q;
  logic       level_valid;
  logic       sensor_err;
  logic       fault;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    logic [2:0] code;
    logic       en;
    logic       clr;
    int         cycles;
    logic       exp_pump;
    logic [2:0] exp_lq;
    logic       exp_valid;
    logic       exp_serr;
    logic       exp_fault;
  } vec_t;

  vec_t vecs[30];

  tank_pump_controller dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .full       (full),
    .half       (half),
    .empty      (empty),
    .fault_clr  (fault_clr),
    .pump_on    (pump_on),
    .level_q    (level_q),
    .level_valid(level_valid),
    .sensor_err (sensor_err),
    .fault      (fault)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic applyStimulus(input logic [2:0] code, input logic en_v,
                               input logic clr_v, input int cycles);
    {full, half, empty} = code;
    en        = en_v;
    fault_clr = clr_v;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] act,
                             input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic checkAll(input string tag, input logic p, input logic [2:0] lq,
                          input logic v, input logic s, input logic f);
    checkOutput({tag, " pump_on"}, 8'(pump_on), 8'(p));
    checkOutput({tag, " level_q"}, 8'(level_q), 8'(lq));
    checkOutput({tag, " level_valid"}, 8'(level_valid), 8'(v));
    checkOutput({tag, " sensor_err"}, 8'(sensor_err), 8'(s));
    checkOutput({tag, " fault"}, 8'(fault), 8'(f));
  endtask

  initial begin
    // Edge numbers in the notes count from the first edge after reset release.
    //            code    en    clr  n   pump  lq    valid serr  fault
    vecs[0]  = '{3'b000, 1'b1, 1'b0, 4,  1'b0, 3'd0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{3'b000, 1'b1, 1'b0, 1,  1'b0, 3'd0, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{3'b000, 1'b1, 1'b0, 1,  1'b1, 3'd0, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{3'b011, 1'b1, 1'b0, 10, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{3'b010, 1'b1, 1'b0, 10, 1'b1, 3'd2, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{3'b110, 1'b1, 1'b0, 10, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{3'b100, 1'b1, 1'b0, 4,  1'b1, 3'd3, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{3'b100, 1'b1, 1'b0, 1,  1'b1, 3'd4, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{3'b100, 1'b1, 1'b0, 1,  1'b0, 3'd4, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{3'b010, 1'b1, 1'b0, 5,  1'b0, 3'd2, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{3'b010, 1'b1, 1'b0, 10, 1'b0, 3'd2, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{3'b011, 1'b1, 1'b0, 5,  1'b0, 3'd1, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{3'b011, 1'b1, 1'b0, 1,  1'b1, 3'd1, 1'b1, 1'b0, 1'b0};
    vecs[13] = '{3'b100, 1'b1, 1'b0, 3,  1'b1, 3'd1, 1'b1, 1'b0, 1'b0};
    vecs[14] = '{3'b011, 1'b1, 1'b0, 6,  1'b1, 3'd1, 1'b1, 1'b0, 1'b0};
    vecs[15] = '{3'b111, 1'b1, 1'b0, 1,  1'b1, 3'd1, 1'b1, 1'b0, 1'b0};
    vecs[16] = '{3'b111, 1'b1, 1'b0, 1,  1'b1, 3'd1, 1'b1, 1'b1, 1'b0};
    vecs[17] = '{3'b111, 1'b1, 1'b0, 1,  1'b1, 3'd1, 1'b1, 1'b1, 1'b0};
    vecs[18] = '{3'b011, 1'b1, 1'b0, 1,  1'b1, 3'd1, 1'b1, 1'b1, 1'b0};
    vecs[19] = '{3'b011, 1'b1, 1'b0, 1,  1'b1, 3'd1, 1'b1, 1'b0, 1'b0};
    vecs[20] = '{3'b111, 1'b1, 1'b0, 4,  1'b1, 3'd1, 1'b1, 1'b1, 1'b0};
    vecs[21] = '{3'b011, 1'b1, 1'b0, 1,  1'b1, 3'd1, 1'b1, 1'b1, 1'b0};
    vecs[22] = '{3'b011, 1'b1, 1'b0, 1,  1'b0, 3'd1, 1'b1, 1'b0, 1'b1};
    vecs[23] = '{3'b011, 1'b1, 1'b1, 1,  1'b0, 3'd1, 1'b1, 1'b0, 1'b0};
    vecs[24] = '{3'b011, 1'b1, 1'b0, 8,  1'b0, 3'd1, 1'b1, 1'b0, 1'b0};
    vecs[25] = '{3'b011, 1'b1, 1'b0, 1,  1'b1, 3'd1, 1'b1, 1'b0, 1'b0};
    vecs[26] = '{3'b011, 1'b0, 1'b0, 1,  1'b0, 3'd1, 1'b1, 1'b0, 1'b0};
    vecs[27] = '{3'b011, 1'b1, 1'b0, 7,  1'b0, 3'd1, 1'b1, 1'b0, 1'b0};
    vecs[28] = '{3'b011, 1'b1, 1'b0, 1,  1'b0, 3'd1, 1'b1, 1'b0, 1'b0};
    vecs[29] = '{3'b011, 1'b1, 1'b0, 1,  1'b1, 3'd1, 1'b1, 1'b0, 1'b0};

    rst = 1'b1;
    {full, half, empty} = 3'b000;
    en        = 1'b1;
    fault_clr = 1'b0;

    // Pump must stay off while reset is held, even with a startable level
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("reset%0d pump_on", k), 8'(pump_on), 8'd0);
    end
    checkAll("reset", 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < 30; i++) begin
      applyStimulus(vecs[i].code, vecs[i].en, vecs[i].clr, vecs[i].cycles);
      checkAll($sformatf("vec%0d", i), vecs[i].exp_pump, vecs[i].exp_lq,
               vecs[i].exp_valid, vecs[i].exp_serr, vecs[i].exp_fault);
    end

    // Asynchronous reset while filling: outputs clear without a clock edge
    rst = 1'b1;
    #2;
    checkAll("async_rst", 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    applyStimulus(3'b000, 1'b1, 1'b0, 2);
    rst = 1'b0;

    // Dry run from reset: FILL at edge 6, fault after 64 cycles of EMPTY
    applyStimulus(3'b000, 1'b1, 1'b0, 69);
    checkAll("dry_e69", 1'b1, 3'd0, 1'b1, 1'b0, 1'b0);
    applyStimulus(3'b000, 1'b1, 1'b0, 1);
    checkAll("dry_e70", 1'b0, 3'd0, 1'b1, 1'b0, 1'b1);
    applyStimulus(3'b000, 1'b1, 1'b0, 3);
    checkAll("dry_hold_fault", 1'b0, 3'd0, 1'b1, 1'b0, 1'b1);
    applyStimulus(3'b000, 1'b1, 1'b1, 1);
    checkAll("clr_e74", 1'b0, 3'd0, 1'b1, 1'b0, 1'b0);
    applyStimulus(3'b000, 1'b1, 1'b0, 8);
    checkAll("lockout_e82", 1'b0, 3'd0, 1'b1, 1'b0, 1'b0);
    applyStimulus(3'b000, 1'b1, 1'b0, 1);
    checkAll("refill_e83", 1'b1, 3'd0, 1'b1, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
